// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bundle: requester valid/last/data/ready, FIFO full flag and write strobe/data,
// plus arbiter status. slave = arbiter side, master = requesters and FIFO controller.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ-1:0]            REQ_LAST;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic                          W_FULL;
  logic                          W_INC;
  logic [DATA_WIDTH-1:0]         WR_DATA;
  logic [NUM_REQ-1:0]            GRANT;
  logic                          BUSY;
  logic                          STALL;

  modport master (
    output REQ_VALID, REQ_LAST, REQ_DATA, W_FULL,
    input  REQ_READY, W_INC, WR_DATA, GRANT, BUSY, STALL
  );

  modport slave (
    input  REQ_VALID, REQ_LAST, REQ_DATA, W_FULL,
    output REQ_READY, W_INC, WR_DATA, GRANT, BUSY, STALL
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for the FIFO write port; optional full-stall timeout (FIFO_ARB_TIMEOUT_EN).
// Grant one cycle after valid in IDLE, then one word/cycle; W_FULL combinationally blocks W_INC and REQ_READY.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic             W_CLK,
  input  logic             W_RST,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [NUM_REQ-1:0]    grant, grant_nxt;
  logic [IW-1:0]         last_grant, last_grant_nxt;
  logic [IW-1:0]         g_idx;
  logic [IW-1:0]         idx;
  logic [NUM_REQ-1:0]    pick;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  valid_g;
  logic                  last_g;
  logic                  w_inc;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_wr_arbiter: NUM_REQ must be 2..4 and TIMEOUT at least 1");
  end

  // Granted index and its data slice; grant is zero in IDLE, so WR_DATA idles at 0.
  always_comb begin
    g_idx  = '0;
    wr_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_idx  = IW'(i);
        wr_dat = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Nearest valid requester after last_grant wins; k = 1 is written last, so it has priority.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (bus.REQ_VALID[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign valid_g = |(bus.REQ_VALID & grant);
  assign last_g  = |(bus.REQ_LAST & grant);
  assign w_inc   = valid_g & ~bus.W_FULL;

  assign bus.W_INC     = w_inc;
  assign bus.WR_DATA   = wr_dat;
  assign bus.REQ_READY = bus.W_FULL ? '0 : grant;
  assign bus.GRANT     = grant;
  assign bus.BUSY      = (state == XFER);

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (|bus.REQ_VALID) begin
          grant_nxt = pick;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_inc && last_g) begin
          grant_nxt      = '0;
          last_grant_nxt = g_idx;
          state_nxt      = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt, stall_cnt_nxt;
  logic          stall_q;

  // Counts consecutive blocked cycles of the current owner; an accepted beat implies !W_FULL and clears it.
  always_comb begin
    stall_cnt_nxt = '0;
    if (state == XFER && bus.W_FULL) begin
      stall_cnt_nxt = (stall_cnt == CW'(TIMEOUT)) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == CW'(TIMEOUT)) begin
        stall_q <= 1'b1;
      end
    end
  end

  assign bus.STALL = stall_q;
`else
  assign bus.STALL = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester drivers, an expected-write scoreboard and a write monitor.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 2;
  localparam int TO = 4;
`ifdef FIFO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed { logic [DW-1:0] d; logic last; } beat_t;
  typedef struct { logic [DW-1:0] d; int g; int cyc; } exp_t;

  logic W_CLK = 1'b0;
  logic W_RST = 1'b1;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .bus   (bus)
  );

  always #5 W_CLK = ~W_CLK;

  beat_t         src_q [NR][$];
  exp_t          exp_q [$];
  logic [NR-1:0] hold;
  logic [NR-1:0] acc;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic push_src(input int r, input logic [DW-1:0] d, input logic last);
    beat_t b;
    b.d    = d;
    b.last = last;
    src_q[r].push_back(b);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int g, input int c);
    exp_t e;
    e.d   = d;
    e.g   = g;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    src_q[0].delete();
    src_q[1].delete();
  endtask

  // Requester drivers: handshake sampled mid-cycle, pop on the edge, next word presented 2 ns later.
  initial begin
    bus.REQ_VALID = '0;
    bus.REQ_LAST  = '0;
    bus.REQ_DATA  = '0;
    forever begin
      @(negedge W_CLK);
      acc = bus.REQ_VALID & bus.REQ_READY;
      @(posedge W_CLK);
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      #2;
      for (int i = 0; i < NR; i++) begin
        logic v;
        v = (src_q[i].size() != 0) && !hold[i];
        bus.REQ_VALID[i]        = v;
        bus.REQ_LAST[i]         = v ? src_q[i][0].last : 1'b0;
        bus.REQ_DATA[i*DW +: DW] = v ? src_q[i][0].d : '0;
      end
    end
  end

  // Write monitor: every FIFO write must match the next expected word, owner and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge W_CLK);
      if (!W_RST && bus.W_INC === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got data 0x%0h in cycle %0d, required no write", bus.WR_DATA, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 64'(bus.WR_DATA), 64'(e.d));
          chk("wr_grant", 64'(bus.GRANT), 64'(1 << e.g));
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int j;
    hold       = '0;
    bus.W_FULL = 1'b0;
    W_RST      = 1'b1;

    // Reset then idle
    @(negedge W_CLK);
    chk("reset_outputs", 64'({bus.GRANT, bus.REQ_READY, bus.W_INC, bus.BUSY, bus.STALL, bus.WR_DATA}), 64'd0);
    repeat (2) tick();
    W_RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge W_CLK);
      chk("idle_outputs", 64'({bus.GRANT, bus.REQ_READY, bus.W_INC, bus.BUSY, bus.STALL, bus.WR_DATA}), 64'd0);
    end

    // Contention: A1 A2 B1 B2 A1 A2 with one idle cycle per packet
    tick();
    k = cyc;
    push_src(0, 8'hA1, 1'b0); push_src(0, 8'hA2, 1'b1);
    push_src(0, 8'hA1, 1'b0); push_src(0, 8'hA2, 1'b1);
    push_src(1, 8'hB1, 1'b0); push_src(1, 8'hB2, 1'b1);
    push_exp(8'hA1, 0, k + 1); push_exp(8'hA2, 0, k + 2);
    push_exp(8'hB1, 1, k + 4); push_exp(8'hB2, 1, k + 5);
    push_exp(8'hA1, 0, k + 7); push_exp(8'hA2, 0, k + 8);
    wait_drain("rr_drain", 40);

    // Full back-pressure for 5 cycles mid-packet
    tick();
    k = cyc;
    push_src(0, 8'hC1, 1'b0); push_src(0, 8'hC2, 1'b0); push_src(0, 8'hC3, 1'b1);
    push_exp(8'hC1, 0, k + 1); push_exp(8'hC2, 0, k + 7); push_exp(8'hC3, 0, k + 8);
    tick();
    tick();
    bus.W_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge W_CLK);
      chk("full_blocks", 64'({bus.W_INC, bus.REQ_READY, bus.BUSY, bus.GRANT}), 64'b0_00_1_01);
      tick();
    end
    bus.W_FULL = 1'b0;
    wait_drain("full_drain", 40);

    // Packet lock: owner drops valid for 3 cycles while requester 1 waits
    tick();
    k = cyc;
    push_src(0, 8'hD1, 1'b0); push_src(0, 8'hD2, 1'b0); push_src(0, 8'hD3, 1'b1);
    push_exp(8'hD1, 0, k + 1); push_exp(8'hD2, 0, k + 5); push_exp(8'hD3, 0, k + 6);
    push_exp(8'hE1, 1, k + 8); push_exp(8'hE2, 1, k + 9);
    tick();
    push_src(1, 8'hE1, 1'b0); push_src(1, 8'hE2, 1'b1);
    tick();
    hold[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge W_CLK);
      chk("lock_hold", 64'({bus.GRANT, bus.W_INC, bus.BUSY}), 64'b01_0_1);
      tick();
    end
    hold[0] = 1'b0;
    wait_drain("lock_drain", 40);

    // Reset mid-packet, then requester 0 wins first with single-beat packets
    tick();
    k = cyc;
    push_src(1, 8'hF1, 1'b0); push_src(1, 8'hF2, 1'b0); push_src(1, 8'hF3, 1'b1);
    push_exp(8'hF1, 1, k + 1);
    tick();
    tick();
    W_RST = 1'b1;
    src_q[1].delete();
    @(negedge W_CLK);
    chk("reset_mid_pkt", 64'({bus.GRANT, bus.REQ_READY, bus.W_INC, bus.BUSY, bus.STALL, bus.WR_DATA}), 64'd0);
    tick();
    W_RST = 1'b0;
    j = cyc;
    push_src(0, 8'h61, 1'b1);
    push_src(1, 8'h71, 1'b1);
    push_exp(8'h61, 0, j + 1);
    push_exp(8'h71, 1, j + 3);
    wait_drain("reset_drain", 40);

    // Full stall: STALL sets after the 4th blocked cycle and is sticky when the timeout is built in
    tick();
    k = cyc;
    push_src(0, 8'h91, 1'b0); push_src(0, 8'h92, 1'b1);
    push_exp(8'h91, 0, k + 1); push_exp(8'h92, 0, k + 7);
    tick();
    tick();
    bus.W_FULL = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge W_CLK);
      chk("stall_flag", 64'(bus.STALL), 64'(TO_EN && s == 4));
      tick();
    end
    bus.W_FULL = 1'b0;
    @(negedge W_CLK);
    chk("stall_sticky", 64'(bus.STALL), 64'(TO_EN));
    wait_drain("stall_drain", 40);
    @(negedge W_CLK);
    chk("stall_idle", 64'(bus.STALL), 64'(TO_EN));
    tick();
    W_RST = 1'b1;
    @(negedge W_CLK);
    chk("stall_reset", 64'(bus.STALL), 64'd0);
    tick();
    W_RST = 1'b0;
    repeat (3) tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
